// File: rtl/pong_ball_ctrl.sv
// pong_ball_ctrl: ball motion engine for pong.
//   Runs a tile-grid ball FSM (IDLE/RUN/MISS/WAIT), bounces off the top/bottom
//   walls and the paddles, reports one-cycle score pulses and rasterises the
//   ball from the VGA column/row counts.
// Ports:
//   i_Clk, i_Rst_n            pixel clock, async active-low reset
//   i_Game_Active             1 = play running
//   i_ColCount, i_RowCount    current pixel position from vga_sync_pulses
//   i_Paddle_Y_P1/P2          top tile row of each paddle
//   o_Ball_X, o_Ball_Y        ball tile position
//   o_Draw_Ball               current pixel is the ball (1-clock latency)
//   o_P1_Scored/o_P2_Scored   one-cycle score pulses
// Optional feature macro: PONG_BALL_SPEEDUP_EN (each paddle hit shortens the
//   step period by c_BALL_SPEED/8, floored at c_BALL_SPEED/4).
module pong_ball_ctrl #(
    parameter int c_TOTAL_COLUMNS = 800,
    parameter int c_TOTAL_ROWS    = 525,
    parameter int c_GAME_WIDTH    = 40,
    parameter int c_GAME_HEIGHT   = 30,
    parameter int c_TILE_BITS     = 4,
    parameter int c_PADDLE_HEIGHT = 6,
    parameter int c_BALL_SPEED    = 1250000
) (
    input  logic       i_Clk,
    input  logic       i_Rst_n,
    input  logic       i_Game_Active,
    input  logic [9:0] i_ColCount,
    input  logic [9:0] i_RowCount,
    input  logic [5:0] i_Paddle_Y_P1,
    input  logic [5:0] i_Paddle_Y_P2,
    output logic [5:0] o_Ball_X,
    output logic [5:0] o_Ball_Y,
    output logic       o_Draw_Ball,
    output logic       o_P1_Scored,
    output logic       o_P2_Scored
);
    localparam int CW = $clog2(c_BALL_SPEED + 1);
    localparam int TW = 10 - c_TILE_BITS;
    localparam logic [5:0] c_X_CTR  = 6'(c_GAME_WIDTH / 2);
    localparam logic [5:0] c_Y_CTR  = 6'(c_GAME_HEIGHT / 2);
    localparam logic [5:0] c_X_MAX  = 6'(c_GAME_WIDTH - 1);
    localparam logic [5:0] c_Y_MAX  = 6'(c_GAME_HEIGHT - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_MISS, S_WAIT} t_state;

    t_state          r_State;
    logic [CW-1:0]   r_Cnt;
    logic [5:0]      r_Ball_X, r_Ball_Y;
    logic            r_Dx_Neg, r_Dy_Neg;   // 1 = moving toward 0
    logic            r_Draw, r_P1_Scored, r_P2_Scored;

    logic            w_Term;
    logic            w_Dy_Neg, w_Dx_Neg;
    logic [5:0]      w_Y_Next, w_X_Next;
    logic            w_Hit, w_Miss_L, w_Miss_R;
    logic            w_In_P1, w_In_P2;
    logic [TW-1:0]   w_Col_Tile, w_Row_Tile;

`ifdef PONG_BALL_SPEEDUP_EN
    localparam int c_DEC = c_BALL_SPEED / 8;
    localparam int c_MIN = c_BALL_SPEED / 4;
    logic [CW-1:0] r_Period;
    logic [CW-1:0] w_Period_Hit;
    // >= rather than == so a period shrink mid-count cannot skip the terminal
    assign w_Term       = (r_Cnt >= r_Period - CW'(1));
    assign w_Period_Hit = (r_Period > CW'(c_MIN + c_DEC)) ? r_Period - CW'(c_DEC)
                                                         : CW'(c_MIN);
`else
    assign w_Term = (r_Cnt == CW'(c_BALL_SPEED - 1));
`endif

    // Paddle windows compared in 7 bits so top+height never wraps
    assign w_In_P1 = ({1'b0, w_Y_Next} >= {1'b0, i_Paddle_Y_P1}) &&
                     ({1'b0, w_Y_Next} <= {1'b0, i_Paddle_Y_P1} + 7'(c_PADDLE_HEIGHT - 1));
    assign w_In_P2 = ({1'b0, w_Y_Next} >= {1'b0, i_Paddle_Y_P2}) &&
                     ({1'b0, w_Y_Next} <= {1'b0, i_Paddle_Y_P2} + 7'(c_PADDLE_HEIGHT - 1));

    // Next ball position/direction if a step happens this cycle
    always_comb begin
        w_Dy_Neg = r_Dy_Neg;
        if (r_Ball_Y == 6'd0)
            w_Dy_Neg = 1'b0;
        else if (r_Ball_Y == c_Y_MAX)
            w_Dy_Neg = 1'b1;
        w_Y_Next = w_Dy_Neg ? r_Ball_Y - 6'd1 : r_Ball_Y + 6'd1;

        w_Dx_Neg = r_Dx_Neg;
        w_X_Next = r_Dx_Neg ? r_Ball_X - 6'd1 : r_Ball_X + 6'd1;
        w_Hit    = 1'b0;
        w_Miss_L = 1'b0;
        w_Miss_R = 1'b0;
        if (r_Ball_X == 6'd1 && r_Dx_Neg) begin
            if (w_In_P1) begin
                w_Hit    = 1'b1;
                w_Dx_Neg = 1'b0;
                w_X_Next = 6'd2;
            end else begin
                w_Miss_L = 1'b1;
                w_X_Next = 6'd0;
            end
        end else if (r_Ball_X == c_X_MAX - 6'd1 && !r_Dx_Neg) begin
            if (w_In_P2) begin
                w_Hit    = 1'b1;
                w_Dx_Neg = 1'b1;
                w_X_Next = c_X_MAX - 6'd2;
            end else begin
                w_Miss_R = 1'b1;
                w_X_Next = c_X_MAX;
            end
        end
    end

    assign w_Col_Tile = i_ColCount[9:c_TILE_BITS];
    assign w_Row_Tile = i_RowCount[9:c_TILE_BITS];

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_State     <= S_IDLE;
            r_Cnt       <= '0;
            r_Ball_X    <= c_X_CTR;
            r_Ball_Y    <= c_Y_CTR;
            r_Dx_Neg    <= 1'b0;
            r_Dy_Neg    <= 1'b0;
            r_Draw      <= 1'b0;
            r_P1_Scored <= 1'b0;
            r_P2_Scored <= 1'b0;
`ifdef PONG_BALL_SPEEDUP_EN
            r_Period    <= CW'(c_BALL_SPEED);
`endif
        end else begin
            r_P1_Scored <= 1'b0;
            r_P2_Scored <= 1'b0;
            r_Draw      <= (w_Col_Tile == TW'(r_Ball_X)) && (w_Row_Tile == TW'(r_Ball_Y));
            case (r_State)
                S_IDLE: begin
                    r_Cnt    <= '0;
                    r_Ball_X <= c_X_CTR;
                    r_Ball_Y <= c_Y_CTR;
`ifdef PONG_BALL_SPEEDUP_EN
                    r_Period <= CW'(c_BALL_SPEED);
`endif
                    if (i_Game_Active)
                        r_State <= S_RUN;
                end
                S_RUN: begin
                    if (!i_Game_Active) begin
                        r_State  <= S_IDLE;
                        r_Cnt    <= '0;
                        r_Ball_X <= c_X_CTR;
                        r_Ball_Y <= c_Y_CTR;
                    end else if (w_Term) begin
                        r_Cnt    <= '0;
                        r_Ball_X <= w_X_Next;
                        r_Ball_Y <= w_Y_Next;
                        r_Dx_Neg <= w_Dx_Neg;
                        r_Dy_Neg <= w_Dy_Neg;
`ifdef PONG_BALL_SPEEDUP_EN
                        if (w_Hit)
                            r_Period <= w_Period_Hit;
`endif
                        // Pulse is registered here so it is high for the MISS cycle
                        if (w_Miss_L) begin
                            r_State     <= S_MISS;
                            r_P2_Scored <= 1'b1;
                        end else if (w_Miss_R) begin
                            r_State     <= S_MISS;
                            r_P1_Scored <= 1'b1;
                        end
                    end else begin
                        r_Cnt <= r_Cnt + CW'(1);
                    end
                end
                S_MISS: begin
                    // Serve toward the player who just conceded
                    r_Dx_Neg <= (r_Ball_X == 6'd0);
                    r_Ball_X <= c_X_CTR;
                    r_Ball_Y <= c_Y_CTR;
                    r_Cnt    <= '0;
`ifdef PONG_BALL_SPEEDUP_EN
                    r_Period <= CW'(c_BALL_SPEED);
`endif
                    r_State  <= S_WAIT;
                end
                default: begin
                    if (!i_Game_Active)
                        r_State <= S_IDLE;
                end
            endcase
        end
    end

    assign o_Ball_X    = r_Ball_X;
    assign o_Ball_Y    = r_Ball_Y;
    assign o_Draw_Ball = r_Draw;
    assign o_P1_Scored = r_P1_Scored;
    assign o_P2_Scored = r_P2_Scored;

    // Frame geometry parameters are carried for integration reference only
    localparam int c_UNUSED_GEOM = c_TOTAL_COLUMNS + c_TOTAL_ROWS;
endmodule
